staff_renderer: RTL
===================

STAFF_RENDERER -- requirements
Module: staff_renderer

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning.
  STAFF_LEFT  64   x of the first staff column
  STAFF_TOP   200  y of the top staff line; legal range 20..600
  NUM_SLOTS   16   number of note slots; fixed power of two
REQ-002 SHALL have ports, one per line: name, direction, width, meaning.
  clk_in           in   1   pixel clock; the only clock
  rst_in           in   1   synchronous, active-high reset
  hcount_in        in   11  current pixel x
  vcount_in        in   10  current pixel y
  data_valid_in    in   1   hcount_in/vcount_in are in the active area
  note_valid_in    in   1   note write request
  note_pitch_in    in   7   MIDI note number of the write request
  note_ready_out   out  1   note write can be accepted this cycle
  clear_in         in   1   one-cycle pulse that empties the note buffer
  staff_pixel_out  out  2   pixel class: 00 background, 01 staff line, 10 note head, 11 cursor
  staff_valid_out  out  1   data_valid_in delayed to align with staff_pixel_out

Function
REQ-003 SHALL render a drawing region x in [STAFF_LEFT, STAFF_LEFT+32*NUM_SLOTS-1], divided into 32-px-wide slots.
  - slot index = (x-STAFF_LEFT)>>5
  - in-slot offset = low 5 bits of (x-STAFF_LEFT)
REQ-004 SHALL draw staff lines inside the region on rows STAFF_TOP+16k and STAFF_TOP+16k+1, for k=0..4.
REQ-005 SHALL store per slot a valid bit and a 4-bit position index q=p+2 (0..12).
  - p is the diatonic step relative to E4 (MIDI 64).
  - Natural notes: C4=-2, D4=-1, E4=0, F4=1, G4=2, A4=3, B4=4, C5=5, D5=6, E5=7, F5=8, G5=9, A5=10.
  - A sharp uses the p of the natural directly below it.
REQ-006 SHALL draw a note head for a valid slot where both conditions hold:
  - in-slot offset is in 12..19
  - y is in yc-4..yc+3, with yc = STAFF_TOP+64-8p
REQ-007 SHALL draw the cursor only while count<NUM_SLOTS:
  - in-slot offset 0..1 of slot index count
  - STAFF_TOP-16 <= y <= STAFF_TOP+80
REQ-008 SHALL resolve overlapping pixel classes by priority: cursor > note head > staff line > background.
  - Every pixel outside the drawing region is 00.
REQ-009 SHALL have a fixed 2-cycle pipeline from hcount_in/vcount_in/data_valid_in to staff_pixel_out/staff_valid_out.
  - Stage 1 registers the slot index, in-slot offset, y, and the slot-memory read.
  - Stage 2 registers the classified pixel.
REQ-010 SHALL transfer a note when note_valid_in && note_ready_out at a rising clock edge.
  - Pitch 60..81: write slot[count] (valid=1, q from REQ-005) and increment count.
  - Any other pitch: complete the handshake but store nothing and leave count unchanged.
REQ-011 SHALL compute note_ready_out combinationally as !rst_in && !clear_in && count<NUM_SLOTS.
  - When full, ready stays low until clear_in; the buffer never overwrites.
REQ-012 SHALL, on clear_in, set count to 0 and every slot's valid bit to 0 at the next edge.
  - clear_in wins over a simultaneous write; that write is not accepted.
REQ-013 SHALL make a write visible to the pixel pipeline from the cycle after it is accepted.
  - During the transition a frame may mix old and new contents; no frame buffering.
REQ-014 SHALL hold count as a 5-bit value in 0..NUM_SLOTS; count SHALL never wrap.

Reset
REQ-015 SHALL, while rst_in is high at an edge, set count=0, all slot valid bits=0, staff_pixel_out=00, staff_valid_out=0, and both pipeline stages' valid bits to 0.
REQ-016 SHALL hold note_ready_out at 0 during reset and at 1 in the first cycle after rst_in falls.
REQ-017 SHALL treat reset asserted mid-frame or mid-handshake as an abort: no write is accepted on that edge.

Verification
REQ-018 Reset then scan the frame -> staff_pixel_out=01 on rows 200,201,216,...,265 for x in 64..575; cursor (11) at x=64..65, y=184..280; 00 elsewhere; staff_valid_out lags data_valid_in by exactly 2 cycles.
REQ-019 Write MIDI 64 then 72 -> slot0 head at x=76..83, y=260..267; slot1 head at x=108..115, y=220..227; cursor moves to x=128..129.
REQ-020 Write MIDI 61 (C#4) and MIDI 90 -> 61 is drawn at the C4 position (y=276..283); 90 is handshaken but not stored; count=1.
REQ-021 Write 16 in-range notes -> note_ready_out=0 after the 16th, cursor gone; a 17th note_valid_in is held off; clear_in -> ready=1 next cycle, all heads gone.
REQ-022 Assert clear_in together with note_valid_in, then assert rst_in during a write -> neither write is accepted; count=0 and outputs are 00 after the reset edge.

Source files
------------

// File: rtl/staff_renderer.sv
// Music staff overlay: draws five staff lines, stored note heads and an
// insertion cursor into a video stream through a fixed 2-cycle pixel pipeline.
module staff_renderer #(
  parameter int unsigned STAFF_LEFT = 64,
  parameter int unsigned STAFF_TOP  = 200,
  parameter int unsigned NUM_SLOTS  = 16
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  input  logic        data_valid_in,
  input  logic        note_valid_in,
  input  logic [6:0]  note_pitch_in,
  output logic        note_ready_out,
  input  logic        clear_in,
  output logic [1:0]  staff_pixel_out,
  output logic        staff_valid_out
);

  localparam int unsigned SLOT_W     = $clog2(NUM_SLOTS);
  localparam int unsigned DX_W       = SLOT_W + 5;
  localparam int unsigned REGION_END = STAFF_LEFT + 32 * NUM_SLOTS;

  // Pitch to staff position q = diatonic step above E4 plus 2; sharps share the natural below.
  function automatic logic [3:0] pitch_to_q(input logic [6:0] pitch);
    logic [3:0] q;
    case (pitch)
      7'd60, 7'd61: q = 4'd0;
      7'd62, 7'd63: q = 4'd1;
      7'd64:        q = 4'd2;
      7'd65, 7'd66: q = 4'd3;
      7'd67, 7'd68: q = 4'd4;
      7'd69, 7'd70: q = 4'd5;
      7'd71:        q = 4'd6;
      7'd72, 7'd73: q = 4'd7;
      7'd74, 7'd75: q = 4'd8;
      7'd76:        q = 4'd9;
      7'd77, 7'd78: q = 4'd10;
      7'd79, 7'd80: q = 4'd11;
      7'd81:        q = 4'd12;
      default:      q = 4'd0;
    endcase
    return q;
  endfunction

  logic [4:0]           count;
  logic [NUM_SLOTS-1:0] slot_valid;
  logic [3:0]           slot_q [NUM_SLOTS];

  logic pitch_ok;
  logic write_en;
  logic not_full;

  assign not_full       = count < 5'(NUM_SLOTS);
  assign note_ready_out = !rst_in && !clear_in && not_full;
  assign pitch_ok       = (note_pitch_in >= 7'd60) && (note_pitch_in <= 7'd81);
  assign write_en       = note_valid_in && note_ready_out && pitch_ok;

  // Note buffer occupancy and per-slot valid bits; clear and reset empty the buffer.
  always_ff @(posedge clk_in) begin
    if (rst_in || clear_in) begin
      count      <= 5'd0;
      slot_valid <= '0;
    end else if (write_en) begin
      slot_valid[count[SLOT_W-1:0]] <= 1'b1;
      count                         <= count + 5'd1;
    end
  end

  // Slot position storage; contents are only meaningful where the valid bit is set.
  always_ff @(posedge clk_in) begin
    if (write_en) begin
      slot_q[count[SLOT_W-1:0]] <= pitch_to_q(note_pitch_in);
    end
  end

  logic            in_region;
  logic [DX_W-1:0] dx;

  assign in_region = ({1'b0, hcount_in} >= 12'(STAFF_LEFT)) &&
                     ({1'b0, hcount_in} <  12'(REGION_END));
  assign dx        = DX_W'(hcount_in - 11'(STAFF_LEFT));

  logic              s1_valid;
  logic              s1_in_region;
  logic [SLOT_W-1:0] s1_slot;
  logic [4:0]        s1_off;
  logic [9:0]        s1_y;
  logic              s1_note_vld;
  logic [3:0]        s1_q;

  // Stage 1: register decoded coordinates and the addressed slot contents.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      s1_valid     <= 1'b0;
      s1_in_region <= 1'b0;
      s1_slot      <= '0;
      s1_off       <= 5'd0;
      s1_y         <= 10'd0;
      s1_note_vld  <= 1'b0;
      s1_q         <= 4'd0;
    end else begin
      s1_valid     <= data_valid_in;
      s1_in_region <= in_region;
      s1_slot      <= dx[DX_W-1:5];
      s1_off       <= dx[4:0];
      s1_y         <= vcount_in;
      s1_note_vld  <= slot_valid[dx[DX_W-1:5]];
      s1_q         <= slot_q[dx[DX_W-1:5]];
    end
  end

  logic [9:0] dy;
  logic [9:0] head_top;
  logic       is_line;
  logic       is_head;
  logic       is_cursor;
  logic [1:0] pixel_next;

  assign dy       = s1_y - 10'(STAFF_TOP);
  assign head_top = 10'(STAFF_TOP + 76) - {3'b000, s1_q, 3'b000};

  // Classify the stage-1 pixel with cursor over head over staff line.
  always_comb begin
    pixel_next = 2'b00;
    is_line    = (s1_y >= 10'(STAFF_TOP)) && (dy <= 10'd65) && (dy[3:1] == 3'b000);
    is_head    = s1_note_vld && (s1_off >= 5'd12) && (s1_off <= 5'd19) &&
                 (s1_y >= head_top) && (s1_y < head_top + 10'd8);
    is_cursor  = not_full && (s1_slot == count[SLOT_W-1:0]) && (s1_off < 5'd2) &&
                 (s1_y >= 10'(STAFF_TOP - 16)) && (s1_y <= 10'(STAFF_TOP + 80));
    if (s1_in_region) begin
      if (is_cursor) begin
        pixel_next = 2'b11;
      end else if (is_head) begin
        pixel_next = 2'b10;
      end else if (is_line) begin
        pixel_next = 2'b01;
      end
    end
  end

  // Stage 2: register the classified pixel and its aligned valid.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      staff_pixel_out <= 2'b00;
      staff_valid_out <= 1'b0;
    end else begin
      staff_pixel_out <= pixel_next;
      staff_valid_out <= s1_valid;
    end
  end

endmodule
